vga_fb_display: RTL and testbench
=================================

Name: vga_fb_display

Overview:
- Parametrised, single-clock VGA display controller. Contains its own timing generator, pixel-clock divider, a scaled framebuffer and a color expander.
- Next generation of the team's fixed 160x120 / 9-bit display. Adds:
  - generic timing, scale and color depth;
  - a valid/ready draw port with out-of-range drop reporting;
  - a hardware fill (screen-clear) engine;
  - full-scale bit-replicated color.
- Sits between the processor's draw-command logic and the DE-series VGA DAC pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- SCALE_SHIFT, 2, log2 of screen pixels per framebuffer pixel, per axis
- CH_BITS, 3, stored bits per color channel (1..8)
- CLK_DIV, 2, Fast_Clock cycles per pixel; power of two, at least 2
- Derived values:
  - FB_W = H_ACTIVE>>SCALE_SHIFT
  - FB_H = V_ACTIVE>>SCALE_SHIFT
  - FB_WORDS = FB_W*FB_H
  - CW = 3*CH_BITS

Ports:
- Fast_Clock  in  1  system clock; the only clock
- Reset_N  in  1  synchronous, active-low reset
- Draw_Valid  in  1  draw request
- Draw_Ready  out  1  block can accept a draw request
- Draw_X  in  16  framebuffer x coordinate
- Draw_Y  in  16  framebuffer y coordinate
- Draw_Color  in  CW  packed {R,G,B} color
- Draw_Dropped  out  1  one-cycle pulse: accepted draw was out of range
- Fill_Start  in  1  start a fill of the whole framebuffer
- Fill_Color  in  CW  fill color
- Busy  out  1  fill in progress
- Frame_Start  out  1  one-cycle pulse at the start of each frame
- VGA_Clk  out  1  pixel clock to the DAC
- VGA_HS  out  1  horizontal sync, active low
- VGA_VS  out  1  vertical sync, active low
- VGA_Blank_N  out  1  high during active video
- VGA_Sync_N  out  1  constant 0
- VGA_Red  out  8  red channel
- VGA_Green  out  8  green channel
- VGA_Blue  out  8  blue channel

Behaviour:
- Reset (Reset_N=0 sampled at a Fast_Clock edge) clears all counters and pipeline registers.
- Output values while in reset:
  - VGA_HS=1, VGA_VS=1, VGA_Blank_N=0
  - RGB=0, VGA_Clk=0
  - Busy=0, Draw_Ready=0, Draw_Dropped=0, Frame_Start=0
- Reset during a fill aborts the fill. RAM contents are undefined/retained and are never cleared by reset.
- Divider:
  - div_cnt counts 0..CLK_DIV-1.
  - pix_en is high when div_cnt==CLK_DIV-1.
  - VGA_Clk is registered high when div_cnt >= CLK_DIV/2, so it rises mid-pixel.
- Timing counters advance on pix_en:
  - hcnt 0..H_TOTAL-1.
  - vcnt increments when hcnt wraps; vcnt 0..V_TOTAL-1.
  - Active region: hcnt<H_ACTIVE and vcnt<V_ACTIVE.
  - HS is low for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - VS follows the same rule using the vertical values.
- Frame_Start pulses for exactly one Fast_Clock cycle when hcnt and vcnt both wrap to 0.
- Read pipeline, 3 pix_en stages:
  - stage 1: address = (vcnt>>SCALE_SHIFT)*FB_W + (hcnt>>SCALE_SHIFT), unsigned and full width.
  - stage 2: registered RAM read.
  - stage 3: color expansion into output registers.
- HS, VS and active are delayed by the same 3 stages, so every output moves together, once per pixel.
- Color expansion: each CH_BITS channel is replicated MSB-first to 8 bits (e.g. 3'b101 -> 8'hB6, 3'b111 -> 8'hFF). RGB is forced to 0 when the delayed active flag is low.
- Draw port:
  - Draw_Ready = (fsm==IDLE), registered.
  - A transfer occurs on a cycle with Draw_Valid & Draw_Ready.
  - In-range transfer (X<FB_W and Y<FB_H): RAM written that same cycle at Y*FB_W+X.
  - Out-of-range transfer: accepted, no write, Draw_Dropped=1 on the next cycle.
  - Draw_Valid while Draw_Ready=0 has no effect; the requester holds it.
- Fill FSM, IDLE -> FILL -> IDLE:
  - In IDLE, Fill_Start latches Fill_Color and moves to FILL on the next cycle.
  - FILL writes address 0..FB_WORDS-1, one per cycle; Busy=1 and Draw_Ready=0 throughout.
  - After the write of FB_WORDS-1, the FSM returns to IDLE. Busy falls and Draw_Ready rises on the following cycle.
  - Fill_Start during FILL is ignored.
  - Fill_Start and a draw transfer in the same IDLE cycle: the draw is written, then the fill begins and overwrites it.
- Read/write to the same address in the same cycle returns the old data (read-before-write).

Decomposition:
- Package vga_pkg:
  - default timing constants;
  - fill_state_t enum {IDLE, FILL};
  - CH_BITS-parametrised color helper function expand_ch().
- Sub-module fb_ram: simple dual-port, single clock, registered read, CW x FB_WORDS, inferred.

Test Plan:
- Reset: hold Reset_N=0 for 10 cycles -> HS=VS=1, Blank_N=0, RGB=0, Busy=0. One cycle after release -> Draw_Ready=1.
- Timing with default parameters:
  - HS low for 192 Fast_Clock cycles every 1600.
  - VS low for 2 lines.
  - Frame_Start period 840000 cycles.
  - Blank_N high for 1280 cycles per active line.
- Draw: draw (0,0) color 9'h1FF, then (159,119) color 9'b101_000_000 ->
  - screen pixels x0..3, y0..3 are FF/FF/FF;
  - pixels x636..639, y476..479 are B6/00/00.
- Drop: draw (160,5) -> Draw_Dropped pulses one cycle, no pixel in the frame changes.
- Fill: Fill_Start with color 9'b001_010_100 ->
  - Busy high for exactly 19200 cycles, Draw_Ready low throughout;
  - next frame all active pixels are 24/49/92.
- Reset mid-fill: assert Reset_N=0 at fill cycle 5000 -> Busy=0 next edge, FSM in IDLE. A new Fill_Start completes normally.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared timing defaults, fill FSM states and color helper for the
//            scaled-framebuffer VGA display.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } tim_t;

    localparam tim_t TIM_RESET = '{hs: 1'b1, vs: 1'b1, act: 1'b0};

    // Replicates the low `bits` bits of ch MSB-first until 8 bits are filled.
    function automatic logic [7:0] expand_ch(input logic [7:0] ch, input int bits);
        logic [7:0] res;
        int         k;
        res = '0;
        k   = bits - 1;
        for (int i = 0; i < 8; i++) begin
            res[3'(7 - i)] = ch[3'(k)];
            k = (k == 0) ? bits - 1 : k - 1;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_fb_display_ram.sv
`default_nettype none
// ============================================================================
// Module   : fb_ram
// Purpose  : Simple dual-port framebuffer RAM, single clock, registered read.
// Revision : 1.0 - initial release
// ============================================================================
module fb_ram #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 19200,
    parameter int unsigned AW    = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register clears on reset; array contents are never cleared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/vga_fb_display.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_display
// Purpose  : VGA timing, scaled framebuffer, draw port, fill engine and
//            bit-replicated color output.
// Revision : 1.0 - initial release
// ============================================================================
module vga_fb_display
    import vga_pkg::*;
#(
    parameter  int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter  int unsigned H_FP        = DEF_H_FP,
    parameter  int unsigned H_SYNC      = DEF_H_SYNC,
    parameter  int unsigned H_BP        = DEF_H_BP,
    parameter  int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter  int unsigned V_FP        = DEF_V_FP,
    parameter  int unsigned V_SYNC      = DEF_V_SYNC,
    parameter  int unsigned V_BP        = DEF_V_BP,
    parameter  int unsigned SCALE_SHIFT = 2,
    parameter  int unsigned CH_BITS     = 3,
    parameter  int unsigned CLK_DIV     = 2,
    localparam int unsigned CW          = 3 * CH_BITS
) (
    input  logic          Fast_Clock,
    input  logic          Reset_N,
    input  logic          Draw_Valid,
    output logic          Draw_Ready,
    input  logic [15:0]   Draw_X,
    input  logic [15:0]   Draw_Y,
    input  logic [CW-1:0] Draw_Color,
    output logic          Draw_Dropped,
    input  logic          Fill_Start,
    input  logic [CW-1:0] Fill_Color,
    output logic          Busy,
    output logic          Frame_Start,
    output logic          VGA_Clk,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_Blank_N,
    output logic          VGA_Sync_N,
    output logic [7:0]    VGA_Red,
    output logic [7:0]    VGA_Green,
    output logic [7:0]    VGA_Blue
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam int unsigned FB_W     = H_ACTIVE >> SCALE_SHIFT;
    localparam int unsigned FB_H     = V_ACTIVE >> SCALE_SHIFT;
    localparam int unsigned FB_WORDS = FB_W * FB_H;
    localparam int unsigned AW       = $clog2(FB_WORDS);
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);
    localparam int unsigned DW       = $clog2(CLK_DIV);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          vga_clk_q, vga_clk_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic          frame_start_q, frame_start_d;
    logic          pix_en, h_wrap, v_wrap;

    tim_t          tim1_q, tim1_d, tim2_q, tim2_d, tim3_q, tim3_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [23:0]   rgb_q, rgb_d;
    logic [CW-1:0] ram_rdata;

    fill_state_t   state_q, state_d;
    logic [AW-1:0] fill_addr_q, fill_addr_d;
    logic [CW-1:0] fill_color_q, fill_color_d;
    logic          ready_q, ready_d;
    logic          dropped_q, dropped_d;
    logic          draw_xfer, draw_in_range;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [CW-1:0] ram_wdata;

    // Divider and raster counters
    always_comb begin
        pix_en        = (div_cnt_q == DW'(CLK_DIV - 1));
        div_cnt_d     = div_cnt_q + DW'(1);
        vga_clk_d     = (div_cnt_q >= DW'(CLK_DIV / 2));
        h_wrap        = (hcnt_q == HW'(H_TOTAL - 1));
        v_wrap        = (vcnt_q == VW'(V_TOTAL - 1));
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        frame_start_d = pix_en & h_wrap & v_wrap;
        if (pix_en) begin
            hcnt_d = h_wrap ? '0 : hcnt_q + HW'(1);
            if (h_wrap) begin
                vcnt_d = v_wrap ? '0 : vcnt_q + VW'(1);
            end
        end
    end

    // Three-stage read pipeline: address, RAM read, color expansion
    always_comb begin
        tim1_d    = tim1_q;
        tim2_d    = tim2_q;
        tim3_d    = tim3_q;
        rd_addr_d = rd_addr_q;
        rgb_d     = rgb_q;
        if (pix_en) begin
            tim1_d.act = (hcnt_q < HW'(H_ACTIVE)) && (vcnt_q < VW'(V_ACTIVE));
            tim1_d.hs  = !((hcnt_q >= HW'(HS_START)) && (hcnt_q < HW'(HS_END)));
            tim1_d.vs  = !((vcnt_q >= VW'(VS_START)) && (vcnt_q < VW'(VS_END)));
            rd_addr_d  = AW'(((32'(vcnt_q) >> SCALE_SHIFT) * FB_W) + (32'(hcnt_q) >> SCALE_SHIFT));
            tim2_d     = tim1_q;
            tim3_d     = tim2_q;
            rgb_d      = '0;
            if (tim2_q.act) begin
                rgb_d = {expand_ch(8'(ram_rdata[2*CH_BITS +: CH_BITS]), CH_BITS),
                         expand_ch(8'(ram_rdata[CH_BITS +: CH_BITS]), CH_BITS),
                         expand_ch(8'(ram_rdata[0 +: CH_BITS]), CH_BITS)};
            end
        end
    end

    // Draw port and fill engine share the single RAM write port
    always_comb begin
        draw_xfer     = Draw_Valid & ready_q;
        draw_in_range = (32'(Draw_X) < FB_W) && (32'(Draw_Y) < FB_H);
        state_d       = state_q;
        fill_addr_d   = fill_addr_q;
        fill_color_d  = fill_color_q;
        ram_we        = 1'b0;
        ram_waddr     = AW'((32'(Draw_Y) * FB_W) + 32'(Draw_X));
        ram_wdata     = Draw_Color;
        case (state_q)
            IDLE: begin
                ram_we = draw_xfer & draw_in_range;
                if (Fill_Start) begin
                    state_d      = FILL;
                    fill_addr_d  = '0;
                    fill_color_d = Fill_Color;
                end
            end
            FILL: begin
                ram_we    = 1'b1;
                ram_waddr = fill_addr_q;
                ram_wdata = fill_color_q;
                if (fill_addr_q == AW'(FB_WORDS - 1)) begin
                    state_d = IDLE;
                end else begin
                    fill_addr_d = fill_addr_q + AW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d   = (state_d == IDLE);
        dropped_d = draw_xfer & ~draw_in_range;
    end

    always_ff @(posedge Fast_Clock) begin
        if (!Reset_N) begin
            div_cnt_q     <= '0;
            vga_clk_q     <= 1'b0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            frame_start_q <= 1'b0;
            tim1_q        <= TIM_RESET;
            tim2_q        <= TIM_RESET;
            tim3_q        <= TIM_RESET;
            rd_addr_q     <= '0;
            rgb_q         <= '0;
            state_q       <= IDLE;
            fill_addr_q   <= '0;
            fill_color_q  <= '0;
            ready_q       <= 1'b0;
            dropped_q     <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            vga_clk_q     <= vga_clk_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            frame_start_q <= frame_start_d;
            tim1_q        <= tim1_d;
            tim2_q        <= tim2_d;
            tim3_q        <= tim3_d;
            rd_addr_q     <= rd_addr_d;
            rgb_q         <= rgb_d;
            state_q       <= state_d;
            fill_addr_q   <= fill_addr_d;
            fill_color_q  <= fill_color_d;
            ready_q       <= ready_d;
            dropped_q     <= dropped_d;
        end
    end

    fb_ram #(
        .WIDTH (CW),
        .DEPTH (FB_WORDS),
        .AW    (AW)
    ) u_fb_ram (
        .clk   (Fast_Clock),
        .rst_n (Reset_N),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (pix_en),
        .raddr (rd_addr_q),
        .rdata (ram_rdata)
    );

    assign Draw_Ready   = ready_q;
    assign Draw_Dropped = dropped_q;
    assign Busy         = (state_q == FILL);
    assign Frame_Start  = frame_start_q;
    assign VGA_Clk      = vga_clk_q;
    assign VGA_HS       = tim3_q.hs;
    assign VGA_VS       = tim3_q.vs;
    assign VGA_Blank_N  = tim3_q.act;
    assign VGA_Sync_N   = 1'b0;
    assign VGA_Red      = rgb_q[23:16];
    assign VGA_Green    = rgb_q[15:8];
    assign VGA_Blue     = rgb_q[7:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_fb_display
// Purpose  : Scoreboard bench for vga_fb_display on a reduced 32x16 raster.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_fb_display;

    localparam int unsigned H_ACTIVE = 32, H_FP = 4, H_SYNC = 8, H_BP = 4;
    localparam int unsigned V_ACTIVE = 16, V_FP = 2, V_SYNC = 2, V_BP = 2;
    localparam int unsigned SCALE_SHIFT = 2, CH_BITS = 3, CLK_DIV = 2;
    localparam int unsigned FB_W = 8, FB_H = 4, FB_WORDS = 32;
    localparam int unsigned HS_LOW_CYC = 16, LINE_CYC = 96, VS_LOW_CYC = 192;
    localparam int unsigned ACTIVE_CYC = 64, FRAME_CYC = 2112;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Draw_Valid, Draw_Ready, Draw_Dropped;
    logic [15:0] Draw_X, Draw_Y;
    logic [8:0]  Draw_Color, Fill_Color;
    logic        Fill_Start, Busy, Frame_Start;
    logic        VGA_Clk, VGA_HS, VGA_VS, VGA_Blank_N, VGA_Sync_N;
    logic [7:0]  VGA_Red, VGA_Green, VGA_Blue;

    always #5 clk = ~clk;

    vga_fb_display #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SCALE_SHIFT(SCALE_SHIFT), .CH_BITS(CH_BITS), .CLK_DIV(CLK_DIV)
    ) dut (
        .Fast_Clock(clk), .Reset_N(rst_n),
        .Draw_Valid(Draw_Valid), .Draw_Ready(Draw_Ready),
        .Draw_X(Draw_X), .Draw_Y(Draw_Y), .Draw_Color(Draw_Color),
        .Draw_Dropped(Draw_Dropped),
        .Fill_Start(Fill_Start), .Fill_Color(Fill_Color), .Busy(Busy),
        .Frame_Start(Frame_Start), .VGA_Clk(VGA_Clk),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_Blank_N(VGA_Blank_N),
        .VGA_Sync_N(VGA_Sync_N),
        .VGA_Red(VGA_Red), .VGA_Green(VGA_Green), .VGA_Blue(VGA_Blue)
    );

    typedef struct {
        int          x;
        int          y;
        logic [23:0] rgb;
    } pix_t;

    pix_t        pix_q[$];
    int          drop_q[$];
    logic [23:0] model [FB_H][FB_W];
    int          vectors = 0;
    int          fails   = 0;
    int          cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Pixel scoreboard: screen position is recovered from the sync/blank stream
    initial begin
        int   x_cyc;
        int   y;
        logic pbl, pvs;
        x_cyc = 0; y = -1; pbl = 1'b0; pvs = 1'b1;
        forever begin
            @(negedge clk);
            if (!VGA_Blank_N) begin
                check("rgb_in_blank", {VGA_Red, VGA_Green, VGA_Blue}, 24'h0);
            end
            if (!rst_n) begin
                x_cyc = 0; y = -1; pbl = 1'b0; pvs = 1'b1;
            end else begin
                if (VGA_VS && !pvs) y = -1;
                if (VGA_Blank_N && !pbl) begin
                    y++;
                    x_cyc = 0;
                end
                if (VGA_Blank_N) begin
                    if ((x_cyc % CLK_DIV) == 0 && pix_q.size() > 0 &&
                        pix_q[0].x == x_cyc / CLK_DIV && pix_q[0].y == y) begin
                        check($sformatf("pixel_%0d_%0d", pix_q[0].x, y),
                              {VGA_Red, VGA_Green, VGA_Blue}, pix_q[0].rgb);
                        void'(pix_q.pop_front());
                    end
                    x_cyc++;
                end
                pbl = VGA_Blank_N;
                pvs = VGA_VS;
            end
        end
    end

    // Drop scoreboard: each expected pulse carries the cycle it must appear in
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && Draw_Dropped) begin
                if (drop_q.size() == 0) begin
                    vectors++;
                    fails++;
                    $display("FAIL drop_unexpected: got pulse at cycle %0d, required none", cyc);
                end else begin
                    check("drop_cycle", cyc, drop_q.pop_front());
                end
            end
        end
    end

    // Raster timing monitor
    initial begin
        int   hs_fall, vs_fall, bl_rise, fs_last;
        logic phs, pvs, pbl;
        hs_fall = -1; vs_fall = -1; bl_rise = -1; fs_last = -1;
        phs = 1'b1; pvs = 1'b1; pbl = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hs_fall = -1; vs_fall = -1; bl_rise = -1; fs_last = -1;
                phs = 1'b1; pvs = 1'b1; pbl = 1'b0;
            end else begin
                if (!VGA_HS && phs) begin
                    if (hs_fall >= 0) check("hs_period", cyc - hs_fall, LINE_CYC);
                    hs_fall = cyc;
                end
                if (VGA_HS && !phs && hs_fall >= 0) check("hs_low", cyc - hs_fall, HS_LOW_CYC);
                if (!VGA_VS && pvs) vs_fall = cyc;
                if (VGA_VS && !pvs && vs_fall >= 0) check("vs_low", cyc - vs_fall, VS_LOW_CYC);
                if (VGA_Blank_N && !pbl) bl_rise = cyc;
                if (!VGA_Blank_N && pbl && bl_rise >= 0) check("blank_high", cyc - bl_rise, ACTIVE_CYC);
                if (Frame_Start) begin
                    if (fs_last >= 0) check("frame_period", cyc - fs_last, FRAME_CYC);
                    fs_last = cyc;
                end
                phs = VGA_HS; pvs = VGA_VS; pbl = VGA_Blank_N;
            end
        end
    end

    task automatic draw(input logic [15:0] x, input logic [15:0] y,
                        input logic [8:0] col, input logic [23:0] rgb);
        int t = 0;
        while (!Draw_Ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("draw_ready", Draw_Ready, 1);
        Draw_Valid = 1'b1; Draw_X = x; Draw_Y = y; Draw_Color = col;
        if (int'(x) < FB_W && int'(y) < FB_H) model[int'(y)][int'(x)] = rgb;
        else drop_q.push_back(cyc + 1);
        @(negedge clk);
        Draw_Valid = 1'b0;
    endtask

    task automatic start_fill(input logic [8:0] col, input bit with_draw);
        check("ready_at_fill_start", Draw_Ready, 1);
        Fill_Start = 1'b1; Fill_Color = col;
        if (with_draw) begin
            Draw_Valid = 1'b1; Draw_X = 16'd2; Draw_Y = 16'd2; Draw_Color = 9'h1FF;
        end
        @(negedge clk);
        Fill_Start = 1'b0; Draw_Valid = 1'b0;
    endtask

    task automatic run_fill(input logic [8:0] col, input logic [23:0] rgb, input bit with_draw);
        int busy_cyc = 0;
        int ready_hi = 0;
        start_fill(col, with_draw);
        while (Busy && busy_cyc < 200) begin
            if (Draw_Ready) ready_hi++;
            Fill_Start = (busy_cyc == 4);
            busy_cyc++;
            @(negedge clk);
        end
        Fill_Start = 1'b0;
        check("fill_busy_cycles", busy_cyc, FB_WORDS);
        check("fill_ready_low", ready_hi, 0);
        check("ready_after_fill", Draw_Ready, 1);
        for (int yy = 0; yy < FB_H; yy++)
            for (int xx = 0; xx < FB_W; xx++)
                model[yy][xx] = rgb;
    endtask

    task automatic check_frame();
        int   t = 0;
        pix_t p;
        while (!Frame_Start && t < 3 * FRAME_CYC) begin
            @(negedge clk);
            t++;
        end
        check("frame_start_seen", Frame_Start, 1);
        for (int sy = 0; sy < V_ACTIVE; sy++) begin
            for (int sx = 0; sx < H_ACTIVE; sx++) begin
                p.x = sx; p.y = sy;
                p.rgb = model[sy >> SCALE_SHIFT][sx >> SCALE_SHIFT];
                pix_q.push_back(p);
            end
        end
        t = 0;
        while (pix_q.size() != 0 && t < 2 * FRAME_CYC) begin
            @(negedge clk);
            t++;
        end
        check("frame_pixels_left", pix_q.size(), 0);
        pix_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; Draw_Valid = 1'b0; Draw_X = '0; Draw_Y = '0; Draw_Color = '0;
        Fill_Start = 1'b0; Fill_Color = '0;
        repeat (10) @(negedge clk);
        check("rst_hs", VGA_HS, 1);
        check("rst_vs", VGA_VS, 1);
        check("rst_blank_n", VGA_Blank_N, 0);
        check("rst_rgb", {VGA_Red, VGA_Green, VGA_Blue}, 24'h0);
        check("rst_vga_clk", VGA_Clk, 0);
        check("rst_busy", Busy, 0);
        check("rst_ready", Draw_Ready, 0);
        check("rst_dropped", Draw_Dropped, 0);
        check("rst_frame_start", Frame_Start, 0);
        check("sync_n", VGA_Sync_N, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", Draw_Ready, 1);

        run_fill(9'b001_010_100, 24'h244992, 1'b0);
        check_frame();

        draw(16'd0, 16'd0, 9'h1FF, 24'hFFFFFF);
        draw(16'd7, 16'd3, 9'b101_000_000, 24'hB60000);
        check_frame();

        draw(16'd8, 16'd2, 9'h1FF, 24'h0);
        draw(16'd3, 16'd4, 9'h1FF, 24'h0);
        draw(16'h8003, 16'd1, 9'h1FF, 24'h0);
        repeat (3) @(negedge clk);
        check("drops_outstanding", drop_q.size(), 0);
        check_frame();

        run_fill(9'b000_111_000, 24'h00FF00, 1'b1);
        check_frame();

        start_fill(9'h000, 1'b0);
        repeat (10) @(negedge clk);
        check("busy_mid_fill", Busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("busy_after_abort", Busy, 0);
        check("ready_in_reset", Draw_Ready, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_abort", Draw_Ready, 1);
        run_fill(9'b111_000_011, 24'hFF006D, 1'b0);
        check_frame();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire
